// File: rtl/rf_xfer_seq.sv
// rf_xfer_seq: sequences 6502 register transfers and optional N/Z update over the
// single register-file port, serving idle-time debug reads.
module rf_xfer_seq #(
    parameter int NUM_REGS = 5,
    parameter int P_ID     = 4,
    parameter int N_BIT    = 7,
    parameter int Z_BIT    = 1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_src_i,
    input  logic [2:0]  req_dst_i,
    input  logic        req_flags_i,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  done_data_o,
    input  logic        dbg_valid_i,
    input  logic [2:0]  dbg_addr_i,
    output logic        dbg_ack_o,
    output logic [7:0]  dbg_data_o,
    output logic [2:0]  rf_addr_o,
    output logic        rf_we_o,
    output logic [15:0] rf_wdata_o,
    input  logic [15:0] rf_rdata_i
);
    localparam logic [2:0] NR  = 3'(NUM_REGS);
    localparam logic [2:0] PID = 3'(P_ID);

    typedef enum logic [2:0] {IDLE, RD_SRC, WR_DST, RD_P, WR_P, DONE, ERR} state_t;

    state_t     state;
    logic [2:0] src, dst;
    logic       flags;
    logic [7:0] tmp, pv, pnew;
    logic       hs;
    logic       rdata_unused;

    assign rdata_unused = ^rf_rdata_i[15:8];
    assign hs = req_valid_i && req_ready_o;

    always_comb begin
        pnew = pv;
        pnew[N_BIT] = tmp[7];
        pnew[Z_BIT] = (tmp == 8'h00);
    end

    // Debug reads only borrow the port in IDLE when no transfer is being accepted
    assign dbg_ack_o  = (state == IDLE) && dbg_valid_i && !hs;
    assign dbg_data_o = (dbg_ack_o && dbg_addr_i < NR) ? rf_rdata_i[7:0] : 8'h00;
    assign rf_we_o    = (state == WR_DST) || (state == WR_P);
    assign rf_wdata_o = (state == WR_DST) ? {8'h00, tmp} : (state == WR_P) ? {8'h00, pnew} : 16'h0000;
    assign rf_addr_o  = (state == RD_SRC) ? src :
                        (state == WR_DST) ? dst :
                        (state == RD_P || state == WR_P) ? PID :
                        dbg_ack_o ? dbg_addr_i : 3'd0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            done_data_o <= 8'h00;
            src         <= 3'd0;
            dst         <= 3'd0;
            flags       <= 1'b0;
            tmp         <= 8'h00;
            pv          <= 8'h00;
        end else begin
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            done_data_o <= 8'h00;
            case (state)
                IDLE: if (hs) begin
                    src         <= req_src_i;
                    dst         <= req_dst_i;
                    flags       <= req_flags_i && (req_dst_i != PID);
                    req_ready_o <= 1'b0;
                    if (req_src_i >= NR || req_dst_i >= NR) begin
                        state  <= ERR;
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                    end else begin
                        state <= RD_SRC;
                    end
                end
                RD_SRC: begin
                    tmp   <= rf_rdata_i[7:0];
                    state <= WR_DST;
                end
                WR_DST: if (flags) begin
                    state <= RD_P;
                end else begin
                    state       <= DONE;
                    done_o      <= 1'b1;
                    done_data_o <= tmp;
                end
                RD_P: begin
                    pv    <= rf_rdata_i[7:0];
                    state <= WR_P;
                end
                WR_P: begin
                    state       <= DONE;
                    done_o      <= 1'b1;
                    done_data_o <= tmp;
                end
                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rf_xfer_seq.sv
// tb_rf_xfer_seq: directed transfers against a transaction-level register model,
// with a per-cycle compare of handshake, completion and debug outputs.
module tb_rf_xfer_seq;
    logic        clk = 1'b0, rstn = 1'b1;
    logic        req_valid = 1'b0, req_flags = 1'b0, dbg_valid = 1'b0;
    logic [2:0]  req_src = 3'd0, req_dst = 3'd0, dbg_addr = 3'd0;
    logic        req_ready, done, err, dbg_ack, rf_we;
    logic [7:0]  done_data, dbg_data;
    logic [2:0]  rf_addr;
    logic [15:0] rf_wdata, rf_rdata;

    logic [7:0]  rf [8];
    logic [7:0]  mrf [8];
    logic        poke = 1'b0;
    logic [2:0]  pa = 3'd0;
    logic [7:0]  pd = 8'h00;
    int          pw = 0;
    int          checks = 0, errors = 0;

    logic [2:0]  cnt = 3'd0;
    logic [2:0]  p_src = 3'd0, p_dst = 3'd0;
    logic        p_ill = 1'b0, p_fe = 1'b0;

    rf_xfer_seq dut (
        .clk_i(clk), .rstn_i(rstn),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_src_i(req_src), .req_dst_i(req_dst), .req_flags_i(req_flags),
        .done_o(done), .err_o(err), .done_data_o(done_data),
        .dbg_valid_i(dbg_valid), .dbg_addr_i(dbg_addr),
        .dbg_ack_o(dbg_ack), .dbg_data_o(dbg_data),
        .rf_addr_o(rf_addr), .rf_we_o(rf_we), .rf_wdata_o(rf_wdata), .rf_rdata_i(rf_rdata)
    );

    always #5 clk = ~clk;

    // Register file environment; the upper read byte is junk the DUT must ignore
    assign rf_rdata = {8'hA5, rf[rf_addr]};
    always @(posedge clk) begin
        if (poke) rf[pa] <= pd;
        else if (rf_we) rf[rf_addr] <= rf_wdata[7:0];
        if (rf_we && rf_addr == 3'd4) pw <= pw + 1;
    end

    function automatic logic [7:0] exp_p(input logic [7:0] p, input logic [7:0] v);
        return (p & 8'h7D) | (v & 8'h80) | ((v == 8'h00) ? 8'h02 : 8'h00);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: cnt counts down the cycles left until done is due
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cnt <= 3'd0;
        else begin
            if (poke) mrf[pa] <= pd;
            if (cnt == 3'd0 && req_valid) begin
                p_src <= req_src;
                p_dst <= req_dst;
                p_ill <= (req_src > 3'd4) || (req_dst > 3'd4);
                p_fe  <= req_flags && req_dst != 3'd4;
                cnt   <= ((req_src > 3'd4) || (req_dst > 3'd4)) ? 3'd1 : (req_flags && req_dst != 3'd4) ? 3'd5 : 3'd3;
            end else if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd1 && !p_ill) begin
                    mrf[p_dst] <= mrf[p_src];
                    if (p_fe) mrf[4] <= exp_p(mrf[4], mrf[p_src]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic bad;
        logic exp_ack;
        chk("ready", req_ready, cnt == 3'd0);
        chk("done", done, cnt == 3'd1);
        chk("err", err, cnt == 3'd1 && p_ill);
        if (cnt == 3'd1) begin
            chk("done_data", done_data, p_ill ? 8'h00 : mrf[p_src]);
            if (!p_ill) chk("dst_value", rf[p_dst], mrf[p_src]);
            if (!p_ill && p_fe) chk("p_value", rf[4], exp_p(mrf[4], mrf[p_src]));
        end
        exp_ack = cnt == 3'd0 && dbg_valid && !req_valid;
        chk("dbg_ack", dbg_ack, exp_ack);
        if (exp_ack) chk("dbg_data", dbg_data, dbg_addr < 3'd5 ? mrf[dbg_addr] : 8'h00);
        if (rf_we) chk("wdata_hi", rf_wdata[15:8], 8'h00);
        if (cnt == 3'd0) begin
            bad = 1'b0;
            for (int j = 0; j < 8; j++) if (rf[j] !== mrf[j]) bad = 1'b1;
            chk("rf_state", bad, 1'b0);
        end
    end

    task automatic load(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        poke = 1'b1; pa = a; pd = d;
        @(posedge clk); #1;
        poke = 1'b0;
    endtask

    task automatic xfer(input logic [2:0] s, input logic [2:0] d, input logic f,
                        input int exp_lat, input logic [7:0] exp_data, input logic exp_err);
        int lat;
        @(posedge clk); #1;
        req_valid = 1'b1; req_src = s; req_dst = d; req_flags = f;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (done) begin lat = j; break; end
        end
        chk("latency", lat, exp_lat);
        chk("xfer_data", done_data, exp_data);
        chk("xfer_err", err, exp_err);
    endtask

    initial begin
        int n;
        #2 rstn = 1'b0;
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_addr", rf_addr, 3'd0);
        chk("rst_wdata", rf_wdata, 16'h0000);
        chk("rst_ddata", done_data, 8'h00);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 5; i < 8; i++) load(3'(i), 8'hEE);
        load(3'd0, 8'h80); load(3'd1, 8'h11); load(3'd2, 8'h00);
        load(3'd3, 8'hFF); load(3'd4, 8'h00);

        xfer(3'd0, 3'd1, 1'b1, 5, 8'h80, 1'b0);
        chk("tax_x", rf[1], 8'h80);
        chk("tax_p", rf[4], 8'h80);

        load(3'd1, 8'h00); load(3'd4, 8'hFF);
        xfer(3'd1, 3'd0, 1'b1, 5, 8'h00, 1'b0);
        chk("txa_a", rf[0], 8'h00);
        chk("txa_p", rf[4], 8'h7F);

        load(3'd1, 8'h42);
        n = pw;
        xfer(3'd1, 3'd3, 1'b0, 3, 8'h42, 1'b0);
        chk("txs_sp", rf[3], 8'h42);
        chk("txs_p", rf[4], 8'h7F);
        chk("txs_pwrites", pw, n);

        load(3'd2, 8'h33);
        xfer(3'd0, 3'd5, 1'b1, 1, 8'h00, 1'b1);
        chk("err_p", rf[4], 8'h7F);
        xfer(3'd7, 3'd1, 1'b0, 1, 8'h00, 1'b1);
        xfer(3'd2, 3'd0, 1'b0, 3, 8'h33, 1'b0);
        chk("tya_a", rf[0], 8'h33);

        @(posedge clk); #1;
        dbg_valid = 1'b1; dbg_addr = 3'd2;
        @(negedge clk);
        chk("dbg_y_ack", dbg_ack, 1'b1);
        chk("dbg_y_data", dbg_data, 8'h33);
        @(posedge clk); #1 dbg_addr = 3'd6;
        @(negedge clk);
        chk("dbg_ill_ack", dbg_ack, 1'b1);
        chk("dbg_ill_data", dbg_data, 8'h00);
        @(posedge clk); #1 dbg_valid = 1'b0;

        @(posedge clk); #1;
        req_valid = 1'b1; req_src = 3'd0; req_dst = 3'd1; req_flags = 1'b0;
        dbg_valid = 1'b1; dbg_addr = 3'd2;
        @(negedge clk);
        chk("dbg_prio", dbg_ack, 1'b0);
        @(posedge clk); #1 req_valid = 1'b0;
        n = 0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (dbg_ack) begin n = j; break; end
        end
        chk("dbg_stall_lat", n, 4);
        chk("dbg_stall_data", dbg_data, 8'h33);
        @(posedge clk); #1 dbg_valid = 1'b0;
        chk("tax2_x", rf[1], 8'h33);

        load(3'd0, 8'h5A);
        xfer(3'd0, 3'd4, 1'b1, 3, 8'h5A, 1'b0);
        chk("dstp_p", rf[4], 8'h5A);
        xfer(3'd2, 3'd2, 1'b1, 5, 8'h33, 1'b0);
        chk("same_y", rf[2], 8'h33);
        chk("same_p", rf[4], 8'h58);

        @(posedge clk); #1;
        req_valid = 1'b1; req_src = 3'd0; req_dst = 3'd1; req_flags = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        chk("wrdst_we", rf_we, 1'b1);
        chk("wrdst_addr", rf_addr, 3'd1);
        rstn = 1'b0;
        #1;
        chk("abort_we", rf_we, 1'b0);
        chk("abort_ready", req_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("post_ready", req_ready, 1'b1);
        chk("post_done", done, 1'b0);
        chk("abort_x", rf[1], 8'h33);
        xfer(3'd0, 3'd1, 1'b0, 3, 8'h5A, 1'b0);
        chk("final_x", rf[1], 8'h5A);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
